// File: rtl/loxodes_seq_monitor.sv
// Channel-enable sequence monitor: validates thermometer-coded channel ramps,
// tracks the validated level and latches pattern/jump/timeout faults until cleared.
module loxodes_seq_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chan_in,
  input  logic [4:0] max_gap,
  input  logic       clear,
  output logic [3:0] level,
  output logic       ramp_up,
  output logic       ramp_down,
  output logic       all_on,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ON        = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_PATTERN = 2'd1;
  localparam logic [1:0] CODE_JUMP    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  state_t     state_reg, state_next;
  logic [7:0] chan_q;
  logic [3:0] level_reg, level_next;
  logic [4:0] gap_cnt_reg, gap_cnt_next;
  logic [1:0] fault_code_reg, fault_code_next;

  logic [7:0] order_ok;
  logic       pattern_ok;
  logic [3:0] obs_level;
  logic [3:0] level_plus1, level_minus1;
  logic       step_up, step_dn, is_hold, is_jump;

  // Thermometer code: every set bit must have its lower neighbour set too.
  assign order_ok[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_therm
      assign order_ok[gi] = chan_q[gi-1] | ~chan_q[gi];
    end
  endgenerate
  assign pattern_ok = &order_ok;

  always_comb begin
    obs_level = 4'd0;
    for (int i = 0; i < 8; i++) begin
      obs_level = obs_level + {3'd0, chan_q[i]};
    end
  end

  assign level_plus1  = level_reg + 4'd1;
  assign level_minus1 = level_reg - 4'd1;
  assign step_up      = pattern_ok && (obs_level == level_plus1);
  assign step_dn      = pattern_ok && (level_reg != 4'd0) && (obs_level == level_minus1);
  assign is_hold      = pattern_ok && (obs_level == level_reg);
  assign is_jump      = pattern_ok && !step_up && !step_dn && !is_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      chan_q         <= 8'd0;
      level_reg      <= 4'd0;
      gap_cnt_reg    <= 5'd0;
      fault_code_reg <= CODE_NONE;
    end else begin
      state_reg      <= state_next;
      chan_q         <= chan_in;
      level_reg      <= level_next;
      gap_cnt_reg    <= gap_cnt_next;
      fault_code_reg <= fault_code_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    level_next      = level_reg;
    gap_cnt_next    = gap_cnt_reg;
    fault_code_next = fault_code_reg;
    if (state_reg == S_FAULT) begin
      gap_cnt_next = 5'd0;
      if (clear && (chan_q == 8'd0)) begin
        state_next      = S_IDLE;
        level_next      = 4'd0;
        fault_code_next = CODE_NONE;
      end
    end else if (!pattern_ok) begin
      state_next      = S_FAULT;
      gap_cnt_next    = 5'd0;
      fault_code_next = CODE_PATTERN;
    end else if (is_jump) begin
      state_next      = S_FAULT;
      gap_cnt_next    = 5'd0;
      fault_code_next = CODE_JUMP;
    end else begin
      case (state_reg)
        S_IDLE: begin
          gap_cnt_next = 5'd0;
          if (step_up) begin
            state_next = S_RAMP_UP;
            level_next = 4'd1;
          end
        end
        S_ON: begin
          gap_cnt_next = 5'd0;
          if (step_dn) begin
            state_next = S_RAMP_DOWN;
            level_next = 4'd7;
          end
        end
        S_RAMP_UP, S_RAMP_DOWN: begin
          if (step_up) begin
            level_next   = level_plus1;
            gap_cnt_next = 5'd0;
            state_next   = (level_plus1 == 4'd8) ? S_ON : S_RAMP_UP;
          end else if (step_dn) begin
            level_next   = level_minus1;
            gap_cnt_next = 5'd0;
            state_next   = (level_minus1 == 4'd0) ? S_IDLE : S_RAMP_DOWN;
          end else if (gap_cnt_reg >= max_gap) begin
            // >= also catches max_gap being lowered below a running count
            state_next      = S_FAULT;
            gap_cnt_next    = 5'd0;
            fault_code_next = CODE_TIMEOUT;
          end else begin
            gap_cnt_next = gap_cnt_reg + 5'd1;
          end
        end
        default: begin
          state_next   = S_IDLE;
          level_next   = 4'd0;
          gap_cnt_next = 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    ramp_up    = (state_reg == S_RAMP_UP);
    ramp_down  = (state_reg == S_RAMP_DOWN);
    all_on     = (state_reg == S_ON);
    fault      = (state_reg == S_FAULT);
    level      = level_reg;
    fault_code = fault_code_reg;
  end

endmodule

// File: tb/tb_loxodes_seq_monitor.sv
// Bench for loxodes_seq_monitor: directed vector table, hand-built corner sequences,
// then randomized traffic checked against a level/direction reference model.
module tb_loxodes_seq_monitor;

  logic       clk;
  logic       reset;
  logic [7:0] chan_in;
  logic [4:0] max_gap;
  logic       clear;
  logic [3:0] level;
  logic       ramp_up, ramp_down, all_on, fault;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  loxodes_seq_monitor dut (
    .clk(clk), .reset(reset), .chan_in(chan_in), .max_gap(max_gap), .clear(clear),
    .level(level), .ramp_up(ramp_up), .ramp_down(ramp_down), .all_on(all_on),
    .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: level plus last step direction; flags derive from those.
  int         m_lvl;
  int         m_dir;
  bit         m_faulted;
  int         m_code;
  int         m_holds;
  logic [7:0] m_q;

  task automatic model_reset();
    m_lvl = 0; m_dir = 0; m_faulted = 0; m_code = 0; m_holds = 0; m_q = 8'd0;
  endtask

  task automatic model_fault(input int c);
    m_faulted = 1; m_code = c; m_holds = 0;
  endtask

  task automatic model_edge(input logic [7:0] cin, input logic clr, input logic [4:0] mg,
                            input logic rst);
    int k;
    bit legal;
    if (rst) begin
      model_reset();
      return;
    end
    k = 0;
    while (k < 8 && m_q[k]) k++;
    legal = ($countones(m_q) == k);
    if (m_faulted) begin
      if (clr && m_q == 8'd0) begin
        m_faulted = 0; m_code = 0; m_lvl = 0; m_holds = 0;
      end
    end else if (!legal) begin
      model_fault(1);
    end else if (k == m_lvl) begin
      if (m_lvl >= 1 && m_lvl <= 7) begin
        if (m_holds >= int'(mg)) model_fault(3);
        else m_holds++;
      end
    end else if (k == m_lvl + 1 || k == m_lvl - 1) begin
      m_dir = k - m_lvl; m_lvl = k; m_holds = 0;
    end else begin
      model_fault(2);
    end
    m_q = cin;
  endtask

  function automatic logic [9:0] model_out();
    logic [3:0] f;
    f = 4'b0000;
    if (m_faulted) f = 4'b0001;
    else if (m_lvl == 8) f = 4'b0010;
    else if (m_lvl >= 1 && m_dir > 0) f = 4'b1000;
    else if (m_lvl >= 1 && m_dir < 0) f = 4'b0100;
    return {4'(m_lvl), f, 2'(m_code)};
  endfunction

  function automatic logic [7:0] therm(input int k);
    logic [8:0] t;
    t = (9'd1 << k) - 9'd1;
    return t[7:0];
  endfunction

  task automatic tick();
    logic [7:0] c   = chan_in;
    logic       cl  = clear;
    logic [4:0] mg  = max_gap;
    logic       rst = reset;
    @(posedge clk);
    model_edge(c, cl, mg, rst);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] lvl, input logic [3:0] flags,
                       input logic [1:0] code);
    logic [9:0] got, exp;
    got = {level, ramp_up, ramp_down, all_on, fault, fault_code};
    exp = {lvl, flags, code};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got level=%0d flags(up,dn,on,flt)=%b code=%0d, expected level=%0d flags=%b code=%0d",
               name, got[9:6], got[5:2], got[1:0], exp[9:6], exp[5:2], exp[1:0]);
    end else begin
      $display("check %s: level=%0d flags=%b code=%0d", name, got[9:6], got[5:2], got[1:0]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; chan_in = 8'd0; clear = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] chan;
    logic       clr;
    logic [4:0] mg;
    int         cycles;
    logic [3:0] lvl;
    logic [3:0] flags;
    logic [1:0] code;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h01, 1'b0, 5'd3, 4,  4'd1, 4'b1000, 2'd0};
    vecs[1]  = '{8'h03, 1'b0, 5'd3, 4,  4'd2, 4'b1000, 2'd0};
    vecs[2]  = '{8'h07, 1'b0, 5'd3, 4,  4'd3, 4'b1000, 2'd0};
    vecs[3]  = '{8'h0F, 1'b0, 5'd3, 4,  4'd4, 4'b1000, 2'd0};
    vecs[4]  = '{8'h1F, 1'b0, 5'd3, 4,  4'd5, 4'b1000, 2'd0};
    vecs[5]  = '{8'h3F, 1'b0, 5'd3, 4,  4'd6, 4'b1000, 2'd0};
    vecs[6]  = '{8'h7F, 1'b0, 5'd3, 4,  4'd7, 4'b1000, 2'd0};
    vecs[7]  = '{8'hFF, 1'b0, 5'd3, 4,  4'd8, 4'b0010, 2'd0};
    vecs[8]  = '{8'h7F, 1'b0, 5'd3, 4,  4'd7, 4'b0100, 2'd0};
    vecs[9]  = '{8'h3F, 1'b0, 5'd3, 4,  4'd6, 4'b0100, 2'd0};
    vecs[10] = '{8'h7F, 1'b0, 5'd3, 4,  4'd7, 4'b1000, 2'd0};
    vecs[11] = '{8'hFF, 1'b0, 5'd3, 4,  4'd8, 4'b0010, 2'd0};
    vecs[12] = '{8'hFF, 1'b1, 5'd3, 10, 4'd8, 4'b0010, 2'd0};

    reset = 1'b1; chan_in = 8'd0; clear = 1'b0; max_gap = 5'd3;
    model_reset();
    tick(); tick();
    check("reset_state", 4'd0, 4'b0000, 2'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      chan_in = vecs[i].chan; clear = vecs[i].clr; max_gap = vecs[i].mg;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_chan%02h", i, vecs[i].chan), vecs[i].lvl, vecs[i].flags, vecs[i].code);
    end
    clear = 1'b0;

    // Timeout, fault hold and clear rules
    max_gap = 5'd2; do_reset();
    chan_in = 8'h01;
    repeat (4) tick();
    check("timeout_pre", 4'd1, 4'b1000, 2'd0);
    tick();
    check("timeout", 4'd1, 4'b0001, 2'd3);
    chan_in = 8'h05;
    repeat (2) tick();
    check("fault_ignores_pattern", 4'd1, 4'b0001, 2'd3);
    chan_in = 8'h03; clear = 1'b1;
    repeat (2) tick();
    check("clear_nonzero_ignored", 4'd1, 4'b0001, 2'd3);
    chan_in = 8'h00;
    tick();
    check("clear_pipeline_lag", 4'd1, 4'b0001, 2'd3);
    tick();
    check("clear_to_idle", 4'd0, 4'b0000, 2'd0);
    clear = 1'b0;

    // Pattern, jump, priority
    max_gap = 5'd3; do_reset();
    chan_in = 8'h05;
    repeat (2) tick();
    check("pattern_from_idle", 4'd0, 4'b0001, 2'd1);
    do_reset();
    check("reset_from_fault", 4'd0, 4'b0000, 2'd0);
    chan_in = 8'h01;
    repeat (2) tick();
    check("jump_setup", 4'd1, 4'b1000, 2'd0);
    chan_in = 8'h07;
    repeat (2) tick();
    check("jump", 4'd1, 4'b0001, 2'd2);
    do_reset();
    chan_in = 8'h01;
    repeat (2) tick();
    chan_in = 8'h0D;
    repeat (2) tick();
    check("pattern_over_jump", 4'd1, 4'b0001, 2'd1);

    // Clear outside FAULT is ignored; max_gap=0 demands a step every cycle
    do_reset();
    clear = 1'b1; chan_in = 8'h01;
    repeat (2) tick();
    check("clear_outside_fault", 4'd1, 4'b1000, 2'd0);
    clear = 1'b0;
    max_gap = 5'd0; do_reset();
    chan_in = 8'h01; tick();
    chan_in = 8'h03; tick();
    chan_in = 8'h07; tick();
    chan_in = 8'h0F; tick();
    check("gap_zero_steps", 4'd3, 4'b1000, 2'd0);
    tick(); tick();
    check("gap_zero_timeout", 4'd4, 4'b0001, 2'd3);

    // Asynchronous reset mid-ramp
    max_gap = 5'd3; do_reset();
    for (int s = 1; s <= 5; s++) begin
      chan_in = therm(s);
      repeat (2) tick();
    end
    check("pre_async_reset", 4'd5, 4'b1000, 2'd0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_no_edge", 4'd0, 4'b0000, 2'd0);
    @(negedge clk);
    reset = 1'b0; chan_in = 8'h01;
    tick();
    check("post_reset_1", 4'd0, 4'b0000, 2'd0);
    tick();
    check("post_reset_2", 4'd1, 4'b1000, 2'd0);

    // Randomized traffic against the reference model
    for (int seg = 0; seg < 4; seg++) begin
      int seg_fail;
      seg_fail = n_fail;
      max_gap = 5'($urandom_range(0, 4));
      do_reset();
      for (int cyc = 0; cyc < 250; cyc++) begin
        int r;
        logic [9:0] exp, got;
        r = $urandom_range(0, 99);
        if (r < 35)      chan_in = therm((m_lvl < 8) ? m_lvl + 1 : 8);
        else if (r < 60) chan_in = therm((m_lvl > 0) ? m_lvl - 1 : 0);
        else if (r < 85) chan_in = therm(m_lvl);
        else if (r < 91) chan_in = 8'($urandom_range(0, 255));
        else if (r < 96) chan_in = therm($urandom_range(0, 8));
        else             chan_in = 8'h00;
        clear = ($urandom_range(0, 4) == 0);
        reset = ($urandom_range(0, 149) == 0);
        tick();
        reset = 1'b0;
        exp = model_out();
        got = {level, ramp_up, ramp_down, all_on, fault, fault_code};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rand_seg%0d_cyc%0d: got level=%0d flags=%b code=%0d, expected level=%0d flags=%b code=%0d",
                   seg, cyc, got[9:6], got[5:2], got[1:0], exp[9:6], exp[5:2], exp[1:0]);
        end
      end
      $display("random segment %0d: max_gap=%0d, 250 cycles, %0d new failures", seg, max_gap,
               n_fail - seg_fail);
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
